// File: rtl/mii_frame_rx_pkg.sv
// Shared types and constants for the MII receive frame delineator.
package mii_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_DATA,
        ST_DROP
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam int unsigned DELAY_DEPTH = 5;
    localparam logic [10:0] LEN_SAT     = 11'd2047;

endpackage

// File: rtl/mii_frame_rx_if.sv
// Byte-in / payload-out bundle of the frame delineator; master is the delineator side.
interface mii_frame_rx_if;
    logic        in_rdy;
    logic [7:0]  in_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_sof;
    logic        out_eof;
    logic        done;
    logic        ok;
    logic        crc_err;
    logic        len_err;
    logic [10:0] frame_len;

    modport master (
        input  in_rdy, in_data,
        output out_valid, out_data, out_sof, out_eof,
        output done, ok, crc_err, len_err, frame_len
    );

    modport slave (
        output in_rdy, in_data,
        input  out_valid, out_data, out_sof, out_eof,
        input  done, ok, crc_err, len_err, frame_len
    );
endinterface

// File: rtl/mii_frame_rx_crc32_d8.sv
// Combinational CRC-32 (reflected 0xEDB88320) update by one byte, LSB first.
module crc32_d8
    import mii_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;
    logic        fb;

    always_comb begin
        c  = crc_in;
        fb = 1'b0;
        for (int unsigned i = 0; i < 8; i++) begin
            fb = c[0] ^ data_in[i];
            c  = {1'b0, c[31:1]} ^ (CRC_POLY & {32{fb}});
        end
        crc_out = c;
    end

endmodule

// File: rtl/mii_frame_rx.sv
// MII receive frame delineator: strips preamble/SFD, streams payload through a
// 5-byte delay line so the FCS is withheld, and reports CRC/length status.
module mii_frame_rx
    import mii_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 4,
    parameter int unsigned MIN_PRE    = 1,
    parameter int unsigned MIN_LEN    = 64,
    parameter int unsigned MAX_LEN    = 1518
) (
    input  logic           mii_clk,
    input  logic           reset,
    mii_frame_rx_if.master bus
);

    localparam logic [3:0]  GAP_LAST  = 4'(GAP_CYCLES - 1);
    localparam logic [3:0]  PRE_MIN   = 4'(MIN_PRE);
    localparam logic [2:0]  LINE_FULL = 3'(DELAY_DEPTH);
    localparam logic [10:0] LEN_MIN   = 11'(MIN_LEN);
    localparam logic [10:0] LEN_MAX   = (MAX_LEN > 2047) ? LEN_SAT : 11'(MAX_LEN);

    rx_state_t       state, state_next;
    logic [3:0]      gap_cnt;
    logic [3:0]      pre_cnt;
    logic [4:0][7:0] line;
    logic [2:0]      fill;
    logic            emitted;
    logic [31:0]     crc, crc_next;
    logic [10:0]     byte_cnt;

    logic gap_event;
    logic enter_data;
    logic data_byte;
    logic frame_end;
    logic is_pre, is_sfd;

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data_in (bus.in_data),
        .crc_out (crc_next)
    );

    always_ff @(posedge mii_clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        is_pre     = (bus.in_data == PREAMBLE_BYTE);
        is_sfd     = (bus.in_data == SFD_BYTE);
        // in_rdy suppresses the gap event even on the cycle it would fire
        gap_event  = (state != ST_IDLE) && !bus.in_rdy && (gap_cnt == GAP_LAST);
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (bus.in_rdy) begin
                    if (is_pre)      state_next = ST_PREAMBLE;
                    else if (is_sfd) state_next = (MIN_PRE == 0) ? ST_DATA : ST_DROP;
                    else             state_next = ST_DROP;
                end
            end
            ST_PREAMBLE: begin
                if (bus.in_rdy) begin
                    if (is_pre)      state_next = ST_PREAMBLE;
                    else if (is_sfd) state_next = (pre_cnt >= PRE_MIN) ? ST_DATA : ST_DROP;
                    else             state_next = ST_DROP;
                end else if (gap_event) begin
                    state_next = ST_IDLE;
                end
            end
            ST_DATA: if (gap_event) state_next = ST_IDLE;
            ST_DROP: if (gap_event) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
        enter_data = (state != ST_DATA) && (state_next == ST_DATA);
        data_byte  = (state == ST_DATA) && bus.in_rdy;
        frame_end  = (state == ST_DATA) && gap_event;
    end

    always_ff @(posedge mii_clk) begin
        if (reset) begin
            gap_cnt       <= '0;
            pre_cnt       <= '0;
            line          <= '0;
            fill          <= '0;
            emitted       <= 1'b0;
            crc           <= '0;
            byte_cnt      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_sof   <= 1'b0;
            bus.out_eof   <= 1'b0;
            bus.done      <= 1'b0;
            bus.ok        <= 1'b0;
            bus.crc_err   <= 1'b0;
            bus.len_err   <= 1'b0;
            bus.frame_len <= '0;
        end else begin
            bus.out_valid <= 1'b0;
            bus.out_sof   <= 1'b0;
            bus.out_eof   <= 1'b0;
            bus.done      <= 1'b0;

            if (state == ST_IDLE || bus.in_rdy) gap_cnt <= '0;
            else if (gap_cnt != 4'hF)           gap_cnt <= gap_cnt + 4'd1;

            if (state == ST_IDLE && bus.in_rdy)
                pre_cnt <= 4'd1;
            else if (state == ST_PREAMBLE && bus.in_rdy && is_pre && pre_cnt != 4'hF)
                pre_cnt <= pre_cnt + 4'd1;

            if (enter_data) begin
                crc      <= CRC_INIT;
                byte_cnt <= '0;
                fill     <= '0;
                emitted  <= 1'b0;
            end

            if (data_byte) begin
                crc  <= crc_next;
                line <= {line[3:0], bus.in_data};
                if (byte_cnt != LEN_SAT) byte_cnt <= byte_cnt + 11'd1;
                if (fill != LINE_FULL)   fill     <= fill + 3'd1;
                if (fill == LINE_FULL) begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= line[4];
                    bus.out_sof   <= !emitted;
                    emitted       <= 1'b1;
                end
            end

            if (frame_end) begin
                if (fill == LINE_FULL) begin
                    bus.out_valid <= 1'b1;
                    bus.out_data  <= line[4];
                    bus.out_sof   <= !emitted;
                    bus.out_eof   <= 1'b1;
                end
                bus.done      <= 1'b1;
                bus.frame_len <= byte_cnt;
                bus.crc_err   <= (crc != CRC_RESIDUE);
                bus.len_err   <= (byte_cnt < LEN_MIN) || (byte_cnt > LEN_MAX);
                bus.ok        <= (crc == CRC_RESIDUE) && (byte_cnt >= LEN_MIN) && (byte_cnt <= LEN_MAX);
            end
        end
    end

endmodule

// File: tb/tb_mii_frame_rx.sv
// Randomized frame bench for mii_frame_rx with a byte-queue reference model.
module tb_mii_frame_rx;
    import mii_pkg::*;

    localparam int GAP  = 4;
    localparam int MINP = 1;
    localparam int MINL = 64;
    localparam int MAXL = 1518;

    logic mii_clk = 1'b0;
    logic reset   = 1'b1;

    mii_frame_rx_if bus();

    mii_frame_rx #(
        .GAP_CYCLES (GAP),
        .MIN_PRE    (MINP),
        .MIN_LEN    (MINL),
        .MAX_LEN    (MAXL)
    ) dut (
        .mii_clk (mii_clk),
        .reset   (reset),
        .bus     (bus)
    );

    always #5 mii_clk = ~mii_clk;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Monitor: collects the emitted payload stream and done pulses.
    logic [7:0] got_q[$];
    int sof_cnt, eof_cnt, sof_idx, eof_idx, done_cnt;

    initial forever begin
        @(negedge mii_clk);
        if (bus.out_valid === 1'b1) begin
            if (bus.out_sof) begin sof_cnt++; sof_idx = got_q.size(); end
            if (bus.out_eof) begin eof_cnt++; eof_idx = got_q.size(); end
            got_q.push_back(bus.out_data);
        end
        if (bus.done === 1'b1) done_cnt++;
    end

    task automatic clear_mon();
        got_q.delete();
        sof_cnt = 0; eof_cnt = 0; sof_idx = -1; eof_idx = -1; done_cnt = 0;
    endtask

    // Reference model state.
    logic [7:0] frm[$];
    logic [7:0] saved[$];
    bit         exp_done;
    int         exp_start, exp_n;
    logic [10:0] exp_flen;
    bit         exp_crc_err, exp_len_err;

    function automatic logic [31:0] fcs_of(input logic [7:0] d[$], input int first, input int n);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int k = first; k < first + n; k++) begin
            c ^= {24'd0, d[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic make_frame(input int npre, input int npay);
        logic [7:0] pay[$];
        logic [31:0] f;
        frm.delete();
        for (int i = 0; i < npre; i++) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int i = 0; i < npay; i++) pay.push_back(8'($urandom));
        if (npay > 9 && pay[9] == 8'hFF) pay[9] = 8'h00;
        f = fcs_of(pay, 0, npay);
        foreach (pay[i]) frm.push_back(pay[i]);
        for (int i = 0; i < 4; i++) frm.push_back(f[8*i +: 8]);
    endtask

    // Expected result derived from the frame bytes alone.
    task automatic model();
        int pre = 0, idx = 0, len;
        logic [31:0] fcs;
        while (idx < frm.size() && frm[idx] == 8'h55) begin pre++; idx++; end
        exp_done = (idx < frm.size()) && (frm[idx] == 8'hD5) && (pre >= MINP);
        exp_start = idx + 1;
        len = exp_done ? frm.size() - exp_start : 0;
        exp_n = (len >= 5) ? len - 4 : 0;
        exp_flen = (len > 2047) ? 11'd2047 : 11'(len);
        exp_len_err = (len < MINL) || (len > MAXL);
        if (len < 4) exp_crc_err = 1'b1;
        else begin
            fcs = fcs_of(frm, exp_start, len - 4);
            exp_crc_err = (fcs != {frm[frm.size()-1], frm[frm.size()-2], frm[frm.size()-3], frm[frm.size()-4]});
        end
    endtask

    task automatic send_bytes(input int lo_min, input int lo_max);
        foreach (frm[i]) begin
            if (i > 0) begin
                repeat ($urandom_range(lo_max, lo_min)) begin
                    @(negedge mii_clk);
                    bus.in_rdy  = 1'b0;
                    bus.in_data = 8'($urandom);
                end
            end
            @(negedge mii_clk);
            bus.in_rdy  = 1'b1;
            bus.in_data = frm[i];
        end
    endtask

    task automatic run_frame(input string tag, input int lo_min, input int lo_max);
        int errs = 0;
        clear_mon();
        model();
        send_bytes(lo_min, lo_max);
        repeat (GAP + 1) begin
            @(negedge mii_clk);
            bus.in_rdy = 1'b0;
        end
        #1;
        check({tag, ".done_cnt"}, done_cnt, exp_done ? 1 : 0);
        check({tag, ".done_now"}, bus.done, exp_done);
        if (exp_done) begin
            check({tag, ".ok"}, bus.ok, !exp_crc_err && !exp_len_err);
            check({tag, ".crc_err"}, bus.crc_err, exp_crc_err);
            check({tag, ".len_err"}, bus.len_err, exp_len_err);
            check({tag, ".frame_len"}, bus.frame_len, exp_flen);
        end
        check({tag, ".n_out"}, got_q.size(), exp_n);
        if (got_q.size() == exp_n) begin
            for (int i = 0; i < exp_n; i++) if (got_q[i] != frm[exp_start + i]) errs++;
            check({tag, ".payload_errs"}, errs, 0);
        end
        if (exp_n > 0) begin
            check({tag, ".sof"}, {sof_cnt[15:0], sof_idx[15:0]}, {16'd1, 16'd0});
            check({tag, ".eof"}, {eof_cnt[15:0], eof_idx[15:0]}, {16'd1, 16'(exp_n - 1)});
            check({tag, ".eof_now"}, bus.out_eof, 1'b1);
        end else begin
            check({tag, ".no_marks"}, sof_cnt + eof_cnt, 0);
        end
    endtask

    initial begin
        int mode, npay;
        bus.in_rdy  = 1'b0;
        bus.in_data = 8'h00;
        clear_mon();
        repeat (3) @(negedge mii_clk);
        check("reset_state", {bus.out_valid, bus.out_sof, bus.out_eof, bus.done, bus.ok,
                              bus.crc_err, bus.len_err, bus.out_data, bus.frame_len}, 0);
        reset = 1'b0;
        repeat (2) @(negedge mii_clk);

        make_frame(7, 60);
        saved = frm;
        run_frame("good", 1, 1);

        frm = saved;
        frm[8 + 9] = 8'hFF;
        run_frame("fcs_err", 1, 1);

        frm = '{8'h55, 8'hD5, 8'h11, 8'h22, 8'h33};
        run_frame("runt", 0, 2);

        make_frame(1, 19);
        frm[1] = 8'h12;
        run_frame("bad_pre", 0, 2);

        make_frame(7, 60);
        run_frame("gap_edge", GAP - 1, GAP - 1);
        make_frame(3, 61);
        run_frame("back2back", 0, 1);

        // Abort mid-frame with reset, then confirm a clean frame decodes.
        clear_mon();
        make_frame(7, 60);
        frm = frm[0:27];
        send_bytes(0, 1);
        @(negedge mii_clk);
        bus.in_rdy = 1'b0;
        reset = 1'b1;
        @(negedge mii_clk);
        check("reset_mid", {bus.out_valid, bus.out_sof, bus.out_eof, bus.done, bus.ok,
                            bus.crc_err, bus.len_err, bus.out_data, bus.frame_len}, 0);
        reset = 1'b0;
        repeat (GAP + 3) @(negedge mii_clk);
        check("reset_no_done", done_cnt + eof_cnt, 0);
        make_frame(7, 60);
        run_frame("after_reset", 0, GAP - 1);

        make_frame(2, 1520);
        run_frame("oversize", 0, 0);
        make_frame(1, 2050);
        run_frame("saturate", 0, 0);

        for (int n = 0; n < 12; n++) begin
            mode = $urandom_range(4, 0);
            npay = $urandom_range(80, 0);
            make_frame($urandom_range(20, 1), npay);
            case (mode)
                1: if (npay > 0) frm[frm.size() - 5] ^= 8'h01;
                2: frm[0] = 8'h5A;
                3: frm.pop_front();
                4: begin frm.pop_back(); frm.pop_back(); end
                default: ;
            endcase
            if (mode == 3) while (frm.size() > 0 && frm[0] == 8'h55) frm.pop_front();
            run_frame($sformatf("rand%0d", n), 0, GAP - 1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
